// File: rtl/segdis_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package segdis_pkg;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    typedef enum logic {
        BLANK,
        SHOW
    } scan_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10-15 show a dash so a corrupted digit is visibly wrong.
module bcd_to_seg7
    import segdis_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (bcd < 4'd10)
            seg = SEG_DIGIT[bcd];
    end

endmodule

// File: rtl/segdis_scan.sv
// Multiplexed common-anode display scanner with frame-aligned updates,
// inter-digit blanking gap and leading-zero suppression.
module segdis_scan
    import segdis_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    mclk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic [IDX_W-1:0]          idx, idx_nxt;
    scan_state_t               state, state_nxt;
    logic [4*NUM_DIGITS-1:0]   shadow_bcd, disp_bcd;
    logic [NUM_DIGITS-1:0]     shadow_dp, disp_dp;

    logic                      cnt_wrap, idx_last, frame_edge;
    logic [NUM_DIGITS-1:0]     lz_mask;
    logic [3:0]                cur_digit;
    logic                      cur_dp, cur_blank;
    logic [6:0]                seg_dec;

    logic [6:0]                seg_nxt;
    logic                      dp_nxt, fd_nxt;
    logic [NUM_DIGITS-1:0]     an_nxt;

    assign cnt_wrap   = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign idx_last   = (idx == IDX_W'(NUM_DIGITS - 1));
    assign frame_edge = cnt_wrap && idx_last;

    // A digit is suppressed when it and everything above it is exactly zero;
    // dashes (10-15) count as nonzero.
    always_comb begin
        logic run;
        run     = 1'b1;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run        = run & (disp_bcd[4*i +: 4] == 4'd0);
            lz_mask[i] = lz_blank & run & (i != 0);
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_nxt    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit = disp_bcd[4*i +: 4];
                cur_dp    = disp_dp[i];
                cur_blank = lz_mask[i];
                an_nxt[i] = 1'b0;
            end
        end
        if (state != SHOW || cur_blank)
            an_nxt = '1;
    end

    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .seg (seg_dec)
    );

    always_comb begin
        cnt_nxt   = cnt_wrap ? '0 : cnt + CNT_W'(1);
        idx_nxt   = idx;
        state_nxt = state;
        if (cnt_wrap)
            idx_nxt = idx_last ? '0 : idx + IDX_W'(1);
        case (state)
            BLANK: if (cnt_nxt == CNT_W'(BLANK_CYCLES)) state_nxt = SHOW;
            SHOW:  if (cnt_wrap) state_nxt = BLANK;
            default: state_nxt = BLANK;
        endcase

        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        fd_nxt  = frame_edge;
        if (state == SHOW && !cur_blank) begin
            seg_nxt = seg_dec;
            dp_nxt  = ~cur_dp;
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            state      <= BLANK;
            shadow_bcd <= '0;
            shadow_dp  <= '0;
            disp_bcd   <= '0;
            disp_dp    <= '0;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            state <= state_nxt;
            if (load) begin
                shadow_bcd <= bcd_in;
                shadow_dp  <= dp_in;
            end
            // A load on the boundary edge goes straight to the display.
            if (frame_edge) begin
                disp_bcd <= load ? bcd_in : shadow_bcd;
                disp_dp  <= load ? dp_in  : shadow_dp;
            end
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            an         <= an_nxt;
            frame_done <= fd_nxt;
        end
    end

endmodule

// File: tb/tb_segdis_scan.sv
// Directed bench for segdis_scan with a short slot (8 cycles, 2 blank).
module tb_segdis_scan;

    logic        mclk = 1'b0;
    logic        rst;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_blank;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int errs   = 0;
    int checks = 0;

    segdis_scan #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .mclk       (mclk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .load       (load),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Starts on the negedge at a frame boundary (j=0) and walks 32 cycles.
    // Sample j reflects slot count j-1 of the frame; digit d shows on
    // j = 8d+3 .. 8d+8. Up to two loads may be issued at chosen cycles.
    task automatic run_frame(input string tag, input logic [3:0] lit,
                             input logic [27:0] segs, input logic [3:0] dpl,
                             input int j1, input logic [15:0] v1, input logic [3:0] p1,
                             input int j2, input logic [15:0] v2, input logic [3:0] p2);
        int low [4];
        int fd, multi, zeros;
        logic [3:0] ea;
        fd = 0;
        multi = 0;
        for (int d = 0; d < 4; d++) low[d] = 0;
        for (int j = 0; j <= 32; j++) begin
            if (j > 0) begin
                zeros = 0;
                for (int d = 0; d < 4; d++) begin
                    if (!an[d]) begin
                        low[d]++;
                        zeros++;
                    end
                end
                if (zeros > 1) multi++;
                if (frame_done) fd++;
                for (int d = 0; d < 4; d++) begin
                    if (j == 8*d + 1) chk($sformatf("%s d%0d gap_an", tag, d), 32'(an), 32'hF);
                    if (j == 8*d + 2) chk($sformatf("%s d%0d gap_seg", tag, d), 32'(seg), 32'h7F);
                    if (j == 8*d + 5) begin
                        ea = 4'hF;
                        if (lit[d]) ea[d] = 1'b0;
                        chk($sformatf("%s d%0d an", tag, d), 32'(an), 32'(ea));
                        chk($sformatf("%s d%0d seg", tag, d), 32'(seg),
                            lit[d] ? 32'(segs[d*7 +: 7]) : 32'h7F);
                        chk($sformatf("%s d%0d dp", tag, d), 32'(dp),
                            (lit[d] && dpl[d]) ? 32'd0 : 32'd1);
                    end
                end
            end
            if (j < 32) begin
                load = 1'b0;
                if (j == j1) begin load = 1'b1; bcd_in = v1; dp_in = p1; end
                if (j == j2) begin load = 1'b1; bcd_in = v2; dp_in = p2; end
                @(negedge mclk);
            end
        end
        load = 1'b0;
        chk({tag, " fd_count"}, 32'(fd), 32'd1);
        chk({tag, " fd_end"}, 32'(frame_done), 32'd1);
        chk({tag, " one_anode"}, 32'(multi), 32'd0);
        for (int d = 0; d < 4; d++)
            chk($sformatf("%s d%0d on_cycles", tag, d), 32'(low[d]), lit[d] ? 32'd6 : 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        bcd_in = '0;
        dp_in = '0;
        lz_blank = 1'b0;
        repeat (3) @(negedge mclk);
        chk("rst an", 32'(an), 32'hF);
        chk("rst seg", 32'(seg), 32'h7F);
        chk("rst dp", 32'(dp), 32'd1);
        chk("rst fd", 32'(frame_done), 32'd0);
        rst = 1'b0;

        // segs packed {d3,d2,d1,d0}
        run_frame("f1_zero", 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000,
                  0, 16'h1234, 4'b0100, -1, 16'h0, 4'h0);
        run_frame("f2_1234", 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0100,
                  0, 16'h0050, 4'b1000, -1, 16'h0, 4'h0);
        lz_blank = 1'b1;
        run_frame("f3_0050", 4'b0011, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1000,
                  0, 16'h0000, 4'b0000, -1, 16'h0, 4'h0);
        run_frame("f4_0000lz", 4'b0001, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000,
                  0, 16'h00A9, 4'b0000, -1, 16'h0, 4'h0);
        lz_blank = 1'b0;
        run_frame("f5_00A9", 4'b1111, {7'h40, 7'h40, 7'h3F, 7'h10}, 4'b0000,
                  12, 16'h7777, 4'b0000, -1, 16'h0, 4'h0);
        run_frame("f6_7777", 4'b1111, {7'h78, 7'h78, 7'h78, 7'h78}, 4'b0000,
                  3, 16'h5555, 4'b0000, 31, 16'h4321, 4'b0000);
        run_frame("f7_4321", 4'b1111, {7'h19, 7'h30, 7'h24, 7'h79}, 4'b0000,
                  -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        // Walk into digit 2's lit window, then reset between clock edges.
        repeat (21) @(negedge mclk);
        chk("pre_rst an", 32'(an), 32'hB);
        chk("pre_rst seg", 32'(seg), 32'h30);
        #2 rst = 1'b1;
        #1;
        chk("async_rst an", 32'(an), 32'hF);
        chk("async_rst seg", 32'(seg), 32'h7F);
        chk("async_rst dp", 32'(dp), 32'd1);
        repeat (2) @(negedge mclk);
        rst = 1'b0;
        run_frame("f8_post_rst", 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000,
                  -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        run_frame("f9_shadow_clr", 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000,
                  -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
